// File: rtl/calc_pkg.sv
// Shared types and constants for the BCD calculator controller.
// Key codes, FSM state encoding and the default adder timeout.
package calc_pkg;

  typedef enum logic [1:0] {
    INGRESO_A,
    INGRESO_B,
    ESPERA,
    MOSTRAR
  } estado_t;

  localparam logic [3:0] TECLA_SUMA   = 4'hA;
  localparam logic [3:0] TECLA_IGUAL  = 4'hB;
  localparam logic [3:0] TECLA_BORRAR = 4'hC;

  localparam int TIMEOUT_DEF = 15;

  function automatic logic es_digito(input logic [3:0] t);
    return t <= 4'd9;
  endfunction

endpackage

// File: rtl/entrada_bcd.sv
// Four-digit BCD shift-in register for operand entry.
// Tracks how many digits are held; full once four are in.
module entrada_bcd (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic            preload,
  input  logic [3:0]      digit,
  output logic [3:0][3:0] value,
  output logic            full
);

  logic [2:0] count;

  assign full = (count == 3'd4);

  // Shift new digits in from the right until four are held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else begin
      unique case (1'b1)
        clr: begin
          value <= '0;
          count <= '0;
        end
        preload: begin
          value <= {12'h000, digit};
          count <= 3'd1;
        end
        load && !full: begin
          value <= {value[2:0], digit};
          count <= count + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_suma.sv
// Keypad controller for a two-operand BCD adder.
// Collects operands, commands the adder, shows its result.
module control_suma
  import calc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tecla_valida,
  input  logic [3:0]      tecla,
  input  logic            ent,
  input  logic [3:0][3:0] resultado,
  output logic [3:0][3:0] numero,
  output logic [3:0][3:0] numero_sv,
  output logic            suma,
  output logic            finalizar,
  output logic [3:0][3:0] display,
  output logic            ocupado,
  output logic            error
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  estado_t         estado_q, estado_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            cargar, limpiar, precargar, lleno;
  logic [3:0][3:0] sv_d, disp_d;
  logic            suma_d, fin_d, err_d;
  logic            k_dig, k_sum, k_igu, k_bor;

  assign k_dig = tecla_valida && es_digito(tecla);
  assign k_sum = tecla_valida && (tecla == TECLA_SUMA);
  assign k_igu = tecla_valida && (tecla == TECLA_IGUAL);
  assign k_bor = tecla_valida && (tecla == TECLA_BORRAR);

  entrada_bcd u_entrada (
    .clk     (clk),
    .rst     (rst),
    .clr     (limpiar),
    .load    (cargar),
    .preload (precargar),
    .digit   (tecla),
    .value   (numero),
    .full    (lleno)
  );

  // State and ESPERA timer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= INGRESO_A;
      tmr_q    <= '0;
    end else begin
      estado_q <= estado_d;
      tmr_q    <= tmr_d;
    end
  end

  // Key decode, next state and next output values
  always_comb begin
    estado_d  = estado_q;
    tmr_d     = '0;
    cargar    = 1'b0;
    limpiar   = 1'b0;
    precargar = 1'b0;
    sv_d      = numero_sv;
    disp_d    = display;
    suma_d    = 1'b0;
    fin_d     = 1'b0;
    err_d     = error;
    if (k_bor) begin
      fin_d    = 1'b1;
      limpiar  = 1'b1;
      sv_d     = '0;
      disp_d   = '0;
      err_d    = 1'b0;
      estado_d = INGRESO_A;
    end else begin
      unique case (estado_q)
        INGRESO_A: begin
          unique case (1'b1)
            k_dig: begin
              err_d = 1'b0;
              if (!lleno) begin
                cargar = 1'b1;
                disp_d = {numero[2:0], tecla};
              end
            end
            k_sum: begin
              sv_d     = numero;
              limpiar  = 1'b1;
              disp_d   = '0;
              estado_d = INGRESO_B;
            end
            default: ;
          endcase
        end
        INGRESO_B: begin
          unique case (1'b1)
            k_dig: begin
              err_d = 1'b0;
              if (!lleno) begin
                cargar = 1'b1;
                disp_d = {numero[2:0], tecla};
              end
            end
            k_igu: begin
              suma_d   = 1'b1;
              estado_d = ESPERA;
            end
            default: ;
          endcase
        end
        ESPERA: begin
          // the suma cycle itself (timer 0) never samples ent
          if ((tmr_q != '0) && ent) begin
            disp_d   = resultado;
            estado_d = MOSTRAR;
          end else if (tmr_q == TMAX) begin
            err_d    = 1'b1;
            fin_d    = 1'b1;
            limpiar  = 1'b1;
            sv_d     = '0;
            disp_d   = '0;
            estado_d = INGRESO_A;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        MOSTRAR: begin
          unique case (1'b1)
            k_sum: begin
              fin_d    = 1'b1;
              sv_d     = display;
              limpiar  = 1'b1;
              disp_d   = '0;
              estado_d = INGRESO_B;
            end
            k_dig: begin
              fin_d     = 1'b1;
              sv_d      = '0;
              precargar = 1'b1;
              disp_d    = {12'h000, tecla};
              err_d     = 1'b0;
              estado_d  = INGRESO_A;
            end
            default: ;
          endcase
        end
        default: estado_d = INGRESO_A;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      numero_sv <= '0;
      display   <= '0;
      suma      <= 1'b0;
      finalizar <= 1'b0;
      ocupado   <= 1'b0;
      error     <= 1'b0;
    end else begin
      numero_sv <= sv_d;
      display   <= disp_d;
      suma      <= suma_d;
      finalizar <= fin_d;
      ocupado   <= (estado_d == ESPERA);
      error     <= err_d;
    end
  end

endmodule

// File: tb/tb_control_suma.sv
// Self-checking bench for control_suma with a behavioural
// adder model and a decimal reference model of the keypad.
module tb_control_suma;

  localparam int T = 15;
  localparam logic [3:0] K_SUM = 4'hA;
  localparam logic [3:0] K_IGU = 4'hB;
  localparam logic [3:0] K_BOR = 4'hC;

  typedef logic [3:0][3:0] bcd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tecla_valida = 1'b0;
  logic [3:0] tecla = 4'h0;
  logic ent = 1'b0;
  bcd_t resultado = '0;
  bcd_t numero, numero_sv, display;
  logic suma, finalizar, ocupado, error;

  int checks = 0;
  int errors = 0;
  int suma_cnt = 0;
  int fin_cnt = 0;
  int both_cnt = 0;

  bit adder_on = 1'b1;
  int adder_lat = 1;
  bit ad_pend = 1'b0;
  int ad_cnt = 0;
  int ad_a = 0;
  int ad_b = 0;

  int m_phase, m_num, m_sv, m_cnt, m_disp, m_fin, m_sum;
  bit m_err;

  control_suma #(.TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .tecla_valida (tecla_valida),
    .tecla        (tecla),
    .ent          (ent),
    .resultado    (resultado),
    .numero       (numero),
    .numero_sv    (numero_sv),
    .suma         (suma),
    .finalizar    (finalizar),
    .display      (display),
    .ocupado      (ocupado),
    .error        (error)
  );

  always #5 clk = ~clk;

  function automatic int from_bcd(input bcd_t x);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[i]);
    return v;
  endfunction

  function automatic bcd_t to_bcd(input int v);
    bcd_t r;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[i] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (suma) suma_cnt++;
    if (finalizar) fin_cnt++;
    if (suma && finalizar) both_cnt++;
  end

  // Adder: latches operands on suma, raises ent after adder_lat cycles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst || finalizar) begin
        ent = 1'b0;
        ad_pend = 1'b0;
      end else if (suma && adder_on) begin
        ad_pend = 1'b1;
        ad_cnt = adder_lat;
        ad_a = from_bcd(numero_sv);
        ad_b = from_bcd(numero);
      end else if (ad_pend) begin
        ad_cnt--;
        if (ad_cnt == 0) begin
          ad_pend = 1'b0;
          resultado = to_bcd((ad_a + ad_b) % 10000);
          ent = 1'b1;
        end
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    tecla_valida = 1'b1;
    tecla = k;
    @(negedge clk);
    tecla_valida = 1'b0;
    tecla = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (ocupado && n < 4 * T) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic m_apply(input logic [3:0] k);
    if (k == K_BOR) begin
      m_num = 0; m_sv = 0; m_cnt = 0;
      m_disp = 0; m_err = 0; m_phase = 0;
      m_fin++;
    end else if (k <= 4'd9) begin
      m_err = 0;
      if (m_phase == 2) begin
        m_fin++;
        m_sv = 0; m_num = int'(k); m_cnt = 1;
        m_disp = m_num; m_phase = 0;
      end else if (m_cnt < 4) begin
        m_num = (m_num * 10 + int'(k)) % 10000;
        m_cnt++;
        m_disp = m_num;
      end
    end else if (k == K_SUM) begin
      if (m_phase != 1) begin
        if (m_phase == 2) m_fin++;
        m_sv = (m_phase == 2) ? m_disp : m_num;
        m_num = 0; m_cnt = 0; m_disp = 0; m_phase = 1;
      end
    end else if (k == K_IGU && m_phase == 1) begin
      m_sum++;
      m_disp = (m_sv + m_num) % 10000;
      m_phase = 2;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({numero, numero_sv, display} !== 48'h0) begin
      errors++;
      $display("FAIL reset_values got %h %h %h want 0",
               numero, numero_sv, display);
    end
    checks++;
    if ({suma, finalizar, ocupado, error} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {suma, finalizar, ocupado, error});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int n, s0;
    adder_lat = 3;
    press(K_BOR);
    press(4'd1); press(4'd2); press(4'd3); press(K_SUM);
    checks++;
    if (numero_sv !== 16'h0123 || numero !== 16'h0) begin
      errors++;
      $display("FAIL basic_sv got %h/%h want 0123/0000",
               numero_sv, numero);
    end
    press(4'd4); press(4'd5);
    checks++;
    if (numero !== 16'h0045 || display !== 16'h0045) begin
      errors++;
      $display("FAIL basic_b got %h/%h want 0045/0045",
               numero, display);
    end
    s0 = suma_cnt;
    press(K_IGU);
    checks++;
    if (suma !== 1'b1 || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse got suma=%b ocupado=%b want 1 1",
               suma, ocupado);
    end
    wait_idle(n);
    @(negedge clk);
    checks++;
    if (n >= 4 * T) begin
      errors++;
      $display("FAIL basic_wait got %0d cycles want <%0d", n, 4 * T);
    end
    checks++;
    if (display !== 16'h0168 || suma_cnt - s0 != 1) begin
      errors++;
      $display("FAIL basic_result got %h pulses=%0d want 0168 1",
               display, suma_cnt - s0);
    end
    checks++;
    if (numero !== 16'h0045 || numero_sv !== 16'h0123) begin
      errors++;
      $display("FAIL basic_hold got %h/%h want 0045/0123",
               numero, numero_sv);
    end
    press(K_IGU);
    @(negedge clk);
    checks++;
    if (display !== 16'h0168 || suma_cnt - s0 != 1) begin
      errors++;
      $display("FAIL igual_in_show got %h pulses=%0d want 0168 1",
               display, suma_cnt - s0);
    end
  endtask

  task automatic test_chain;
    int n, f0;
    f0 = fin_cnt;
    press(K_SUM);
    checks++;
    if (finalizar !== 1'b1 || numero_sv !== 16'h0168 ||
        numero !== 16'h0) begin
      errors++;
      $display("FAIL chain_sum got fin=%b %h/%h want 1 0168/0000",
               finalizar, numero_sv, numero);
    end
    press(4'd2);
    checks++;
    if (numero !== 16'h0002) begin
      errors++;
      $display("FAIL chain_digit got %h want 0002", numero);
    end
    press(K_IGU);
    wait_idle(n);
    @(negedge clk);
    checks++;
    if (display !== 16'h0170 || fin_cnt - f0 != 1) begin
      errors++;
      $display("FAIL chain_result got %h fin=%0d want 0170 1",
               display, fin_cnt - f0);
    end
  endtask

  task automatic test_full;
    press(K_BOR);
    for (int i = 1; i <= 5; i++) press(4'(i));
    checks++;
    if (numero !== 16'h1234 || display !== 16'h1234) begin
      errors++;
      $display("FAIL full_5 got %h/%h want 1234", numero, display);
    end
    press(4'd6);
    checks++;
    if (numero !== 16'h1234) begin
      errors++;
      $display("FAIL full_6 got %h want 1234", numero);
    end
  endtask

  task automatic test_timeout;
    int n, f0;
    adder_on = 1'b0;
    press(K_BOR);
    press(4'd1); press(K_SUM); press(4'd2);
    f0 = fin_cnt;
    press(K_IGU);
    wait_idle(n);
    checks++;
    if (n != T + 1) begin
      errors++;
      $display("FAIL timeout_busy got %0d cycles want %0d", n, T + 1);
    end
    checks++;
    if (error !== 1'b1 || finalizar !== 1'b1 ||
        {numero, numero_sv, display} !== 48'h0) begin
      errors++;
      $display("FAIL timeout_state got err=%b fin=%b %h %h %h",
               error, finalizar, numero, numero_sv, display);
    end
    @(negedge clk);
    checks++;
    if (fin_cnt - f0 != 1) begin
      errors++;
      $display("FAIL timeout_fin got %0d want 1", fin_cnt - f0);
    end
    press(4'd3);
    checks++;
    if (error !== 1'b0 || numero !== 16'h0003) begin
      errors++;
      $display("FAIL timeout_clear got err=%b %h want 0 0003",
               error, numero);
    end
    adder_on = 1'b1;
  endtask

  task automatic test_borrar;
    int f0;
    press(K_BOR);
    press(4'd9); press(4'd9); press(K_SUM);
    checks++;
    if (numero_sv !== 16'h0099) begin
      errors++;
      $display("FAIL borrar_setup got %h want 0099", numero_sv);
    end
    press(4'd4);
    f0 = fin_cnt;
    press(K_BOR);
    @(negedge clk);
    checks++;
    if (fin_cnt - f0 != 1) begin
      errors++;
      $display("FAIL borrar_fin got %0d want 1", fin_cnt - f0);
    end
    checks++;
    if ({numero, numero_sv, display} !== 48'h0 ||
        {suma, ocupado, error} !== 3'b0) begin
      errors++;
      $display("FAIL borrar_zero got %h %h %h", numero, numero_sv,
               display);
    end
    press(4'd7);
    checks++;
    if (numero !== 16'h0007) begin
      errors++;
      $display("FAIL borrar_next got %h want 0007", numero);
    end
  endtask

  task automatic test_borrar_espera;
    int s0, f0;
    adder_on = 1'b0;
    press(K_BOR);
    press(4'd5); press(K_SUM); press(4'd5); press(K_IGU);
    @(negedge clk);
    @(negedge clk);
    f0 = fin_cnt;
    press(K_BOR);
    @(negedge clk);
    s0 = suma_cnt;
    checks++;
    if (ocupado !== 1'b0 || fin_cnt - f0 != 1 ||
        {numero, numero_sv, display} !== 48'h0) begin
      errors++;
      $display("FAIL borrar_espera got busy=%b fin=%0d %h %h",
               ocupado, fin_cnt - f0, numero, numero_sv);
    end
    repeat (2 * T) @(negedge clk);
    checks++;
    if (suma_cnt != s0 || fin_cnt - f0 != 1) begin
      errors++;
      $display("FAIL borrar_espera_quiet got suma=%0d fin=%0d",
               suma_cnt - s0, fin_cnt - f0);
    end
    adder_on = 1'b1;
  endtask

  task automatic test_reset_espera;
    int s0, f0;
    adder_on = 1'b0;
    press(K_BOR);
    press(4'd1); press(K_SUM); press(4'd1); press(K_IGU);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({numero, numero_sv, display} !== 48'h0 ||
        {suma, finalizar, ocupado, error} !== 4'b0) begin
      errors++;
      $display("FAIL rst_async got %h %h %h flags %b", numero,
               numero_sv, display, {suma, finalizar, ocupado, error});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    s0 = suma_cnt;
    f0 = fin_cnt;
    repeat (2 * T + 4) @(negedge clk);
    checks++;
    if (suma_cnt != s0 || fin_cnt != f0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet got suma=%0d fin=%0d busy=%b",
               suma_cnt - s0, fin_cnt - f0, ocupado);
    end
    adder_on = 1'b1;
    press(4'd4);
    checks++;
    if (numero !== 16'h0004) begin
      errors++;
      $display("FAIL rst_resume got %h want 0004", numero);
    end
  endtask

  task automatic test_random;
    int n, r, f0, s0;
    logic [3:0] k;
    bit in_b;
    press(K_BOR);
    @(negedge clk);
    m_phase = 0; m_num = 0; m_sv = 0; m_cnt = 0;
    m_disp = 0; m_err = 0; m_fin = 0; m_sum = 0;
    f0 = fin_cnt;
    s0 = suma_cnt;
    repeat (150) begin
      r = $urandom_range(0, 19);
      k = (r < 16) ? 4'(r) : ((r < 18) ? K_SUM : K_IGU);
      adder_lat = $urandom_range(1, T);
      in_b = (m_phase == 1);
      press(k);
      if (k == K_IGU && in_b) begin
        wait_idle(n);
        checks++;
        if (n >= 4 * T) begin
          errors++;
          $display("FAIL rand_wait got %0d want <%0d", n, 4 * T);
        end
      end
      m_apply(k);
      checks++;
      if (numero !== to_bcd(m_num) || numero_sv !== to_bcd(m_sv)) begin
        errors++;
        $display("FAIL rand_ops key=%h got %h/%h want %h/%h", k,
                 numero, numero_sv, to_bcd(m_num), to_bcd(m_sv));
      end
      checks++;
      if (display !== to_bcd(m_disp) || error !== m_err) begin
        errors++;
        $display("FAIL rand_disp key=%h got %h e=%b want %h e=%b", k,
                 display, error, to_bcd(m_disp), m_err);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (fin_cnt - f0 != m_fin || suma_cnt - s0 != m_sum) begin
      errors++;
      $display("FAIL rand_pulses got fin=%0d suma=%0d want %0d %0d",
               fin_cnt - f0, suma_cnt - s0, m_fin, m_sum);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_chain;
    test_full;
    test_timeout;
    test_borrar;
    test_borrar_espera;
    test_reset_espera;
    test_random;
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL pulse_overlap got %0d want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
